// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/execute controller for the core datapath.
// Fetches 16-bit instructions over a req/ack port, decodes the opcode, drives
// the datapath control fields, runs data-memory loads/stores, branches and halt.
//
// Handshake rule (both memory ports): the request is high for as long as the
// sequencer sits in the requesting state, and address/we stay stable there.
// The transfer completes on the first rising edge where req and ack are both 1.
// An ack seen while req is low is ignored. rst wins over a same-cycle ack.
module core_sequencer #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [11:0]     operands,
    output logic            reg_wr_en,
    output logic [3:0]      alu_cmd,
    output logic [1:0]      dst_in_sel,
    input  logic            alu_zero,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_BZ  = 4'hC;
    localparam logic [3:0] OP_RS0 = 4'hD;
    localparam logic [3:0] OP_RS1 = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            z_flag;
    logic            illegal_q;

    logic [3:0]      opcode;
    logic            is_alu;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_target;

    // Shared decode terms; the branch target is the zero-extended 8-bit field.
    assign opcode    = ir[15:12];
    assign is_alu    = ~ir[15];
    assign pc_inc    = pc + PC_W'(1);
    assign br_target = PC_W'(ir[7:0]);

    // Sequencer state, program counter, instruction register and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RST_PC;
            ir        <= '0;
            z_flag    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_alu) begin
                        // Only ALU ops touch the flag, so BZ sees the last ALU result.
                        z_flag <= alu_zero;
                        pc     <= pc_inc;
                        state  <= S_FETCH;
                    end else begin
                        case (opcode)
                            OP_LDI: begin
                                pc    <= pc_inc;
                                state <= S_FETCH;
                            end
                            OP_LD, OP_ST: begin
                                state <= S_MEM;
                            end
                            OP_JMP: begin
                                pc    <= br_target;
                                state <= S_FETCH;
                            end
                            OP_BZ: begin
                                pc    <= z_flag ? br_target : pc_inc;
                                state <= S_FETCH;
                            end
                            OP_RS0, OP_RS1: begin
                                illegal_q <= 1'b1;
                                pc        <= pc_inc;
                                state     <= S_FETCH;
                            end
                            OP_HLT: begin
                                state <= S_HALT;
                            end
                            default: begin
                                state <= S_FETCH;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        pc    <= pc_inc;
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Control outputs decoded from state and IR; the LD write-back waits on dmem_ack.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = pc;
        operands   = ir[11:0];
        alu_cmd    = {1'b0, ir[14:12]};
        reg_wr_en  = 1'b0;
        dst_in_sel = SEL_ALU;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        illegal    = illegal_q;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
            end
            S_EXEC: begin
                if (is_alu) begin
                    reg_wr_en  = 1'b1;
                    dst_in_sel = SEL_ALU;
                end else if (opcode == OP_LDI) begin
                    reg_wr_en  = 1'b1;
                    dst_in_sel = SEL_IMM;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_ST);
                if (opcode == OP_LD && dmem_ack) begin
                    reg_wr_en  = 1'b1;
                    dst_in_sel = SEL_MEM;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-cycle vector table checking every output, with
// an instruction-memory model and a fetch-address scoreboard.
module tb_core_sequencer;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [15:0]     imem_data;
    logic [11:0]     operands;
    logic            reg_wr_en;
    logic [3:0]      alu_cmd;
    logic [1:0]      dst_in_sel;
    logic            alu_zero = 1'b0;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack = 1'b0;
    logic            halted;
    logic            illegal;

    int n_checks = 0;
    int n_pass   = 0;

    core_sequencer #(.PC_W(PC_W), .RST_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .operands(operands), .reg_wr_en(reg_wr_en), .alu_cmd(alu_cmd), .dst_in_sel(dst_in_sel),
        .alu_zero(alu_zero), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .halted(halted), .illegal(illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    // instruction memory model
    logic [15:0] imem [256];
    assign imem_data = imem[imem_addr];

    typedef struct packed {
        logic        ireq;
        logic [7:0]  iaddr;
        logic [11:0] opnd;
        logic        wr;
        logic [3:0]  cmd;
        logic [1:0]  sel;
        logic        dreq;
        logic        dwe;
        logic        hlt;
        logic        ill;
    } out_t;

    typedef struct {
        logic rst;
        logic iack;
        logic az;
        logic dack;
        out_t exp;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];

    function automatic out_t ex(input logic ireq, input logic [7:0] a, input logic [11:0] op,
                                input logic wr, input logic [3:0] cmd, input logic [1:0] sel,
                                input logic dr, input logic dw, input logic h, input logic il);
        out_t o;
        o.ireq = ireq; o.iaddr = a; o.opnd = op; o.wr = wr; o.cmd = cmd;
        o.sel = sel; o.dreq = dr; o.dwe = dw; o.hlt = h; o.ill = il;
        return o;
    endfunction

    task automatic add(input logic r, input logic ia, input logic az, input logic da, input out_t e);
        vec_t v;
        v.rst = r; v.iack = ia; v.az = az; v.dack = da; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    // driver: apply each row at negedge, check all outputs 1 time unit later
    task automatic run_table(input string name);
        out_t act;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst      = tbl[i].rst;
            imem_ack = tbl[i].iack;
            alu_zero = tbl[i].az;
            dmem_ack = tbl[i].dack;
            if (!tbl[i].rst && tbl[i].iack && tbl[i].exp.ireq)
                exp_q.push_back(tbl[i].exp.iaddr);
            #1;
            act = {imem_req, imem_addr, operands, reg_wr_en, alu_cmd, dst_in_sel,
                   dmem_req, dmem_we, halted, illegal};
            n_checks++;
            if (act === tbl[i].exp) n_pass++;
            else $display("FAIL %s row %0d: got %h expected %h", name, i, act, tbl[i].exp);
        end
        tbl.delete();
    endtask

    // scoreboard: every accepted fetch must match the next expected address
    always @(negedge clk) begin
        logic [7:0] e;
        #2;
        if (rst === 1'b0 && imem_req === 1'b1 && imem_ack === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL fetch_order: got unexpected fetch at %h, expected none", imem_addr);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr === e) n_pass++;
                else $display("FAIL fetch_addr: got %h expected %h", imem_addr, e);
            end
        end
    end

    initial begin
        clear_mem();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Segment A: LDI, ALU+BZ taken/not taken, LD/ST with wait states, JMP and wrap
        imem[8'h00] = 16'h812A;
        imem[8'h01] = 16'h1234;
        imem[8'h02] = 16'hC040;
        imem[8'h40] = 16'h2000;
        imem[8'h41] = 16'hC040;
        imem[8'h42] = 16'h9005;
        imem[8'h43] = 16'hA006;
        imem[8'h44] = 16'hB0FF;
        imem[8'hFF] = 16'h3001;
        add(0,1,0,0, ex(1,8'h00,12'h000,0,4'd0,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'h00,12'h12A,1,4'd0,2'd1,0,0,0,0));
        add(0,1,0,0, ex(1,8'h01,12'h12A,0,4'd0,2'd0,0,0,0,0));
        add(0,1,1,0, ex(0,8'h01,12'h234,1,4'd1,2'd0,0,0,0,0));
        add(0,1,0,0, ex(1,8'h02,12'h234,0,4'd1,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'h02,12'h040,0,4'd4,2'd0,0,0,0,0));
        add(0,0,0,0, ex(1,8'h40,12'h040,0,4'd4,2'd0,0,0,0,0));
        add(0,1,0,0, ex(1,8'h40,12'h040,0,4'd4,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'h40,12'h000,1,4'd2,2'd0,0,0,0,0));
        add(0,1,0,0, ex(1,8'h41,12'h000,0,4'd2,2'd0,0,0,0,0));
        add(0,1,1,0, ex(0,8'h41,12'h040,0,4'd4,2'd0,0,0,0,0));
        add(0,1,0,0, ex(1,8'h42,12'h040,0,4'd4,2'd0,0,0,0,0));
        add(0,0,0,1, ex(0,8'h42,12'h005,0,4'd1,2'd0,0,0,0,0));
        add(0,0,0,0, ex(0,8'h42,12'h005,0,4'd1,2'd0,1,0,0,0));
        add(0,0,0,0, ex(0,8'h42,12'h005,0,4'd1,2'd0,1,0,0,0));
        add(0,0,0,1, ex(0,8'h42,12'h005,1,4'd1,2'd2,1,0,0,0));
        add(0,1,0,0, ex(1,8'h43,12'h005,0,4'd1,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'h43,12'h006,0,4'd2,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'h43,12'h006,0,4'd2,2'd0,1,1,0,0));
        add(0,0,0,0, ex(0,8'h43,12'h006,0,4'd2,2'd0,1,1,0,0));
        add(0,0,0,1, ex(0,8'h43,12'h006,0,4'd2,2'd0,1,1,0,0));
        add(0,1,0,0, ex(1,8'h44,12'h006,0,4'd2,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'h44,12'h0FF,0,4'd3,2'd0,0,0,0,0));
        add(0,1,0,0, ex(1,8'hFF,12'h0FF,0,4'd3,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'hFF,12'h001,1,4'd3,2'd0,0,0,0,0));
        add(0,0,0,0, ex(1,8'h00,12'h001,0,4'd3,2'd0,0,0,0,0));
        run_table("seq_a");

        // Segment B: reserved opcode, ALU, HLT, 20 halted cycles with acks high, reset
        clear_mem();
        imem[8'h00] = 16'hD000;
        imem[8'h01] = 16'h0000;
        imem[8'h02] = 16'hF000;
        add(1,0,0,0, ex(1,8'h00,12'h001,0,4'd3,2'd0,0,0,0,0));
        add(0,1,0,0, ex(1,8'h00,12'h000,0,4'd0,2'd0,0,0,0,0));
        add(0,1,0,0, ex(0,8'h00,12'h000,0,4'd5,2'd0,0,0,0,0));
        add(0,1,0,0, ex(1,8'h01,12'h000,0,4'd5,2'd0,0,0,0,1));
        add(0,1,1,0, ex(0,8'h01,12'h000,1,4'd0,2'd0,0,0,0,1));
        add(0,1,0,0, ex(1,8'h02,12'h000,0,4'd0,2'd0,0,0,0,1));
        add(0,1,0,0, ex(0,8'h02,12'h000,0,4'd7,2'd0,0,0,0,1));
        for (int k = 0; k < 20; k++)
            add(0,1,1,1, ex(0,8'h02,12'h000,0,4'd7,2'd0,0,0,1,1));
        add(1,1,1,1, ex(0,8'h02,12'h000,0,4'd7,2'd0,0,0,1,1));
        add(0,0,0,0, ex(1,8'h00,12'h000,0,4'd0,2'd0,0,0,0,0));
        run_table("seq_b");

        // Segment C: reset in the same cycle as a fetch ack discards the word
        clear_mem();
        imem[8'h00] = 16'h8155;
        imem[8'h01] = 16'h4321;
        add(0,1,0,0, ex(1,8'h00,12'h000,0,4'd0,2'd0,0,0,0,0));
        add(0,0,0,0, ex(0,8'h00,12'h155,1,4'd0,2'd1,0,0,0,0));
        add(1,1,0,0, ex(1,8'h01,12'h155,0,4'd0,2'd0,0,0,0,0));
        add(0,0,0,0, ex(1,8'h00,12'h000,0,4'd0,2'd0,0,0,0,0));
        run_table("seq_c");

        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL fetch_drain: got %0d pending fetches expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
